// File: rtl/resize_pkg.sv
// ---------------------------------------------------------------------------
// resize_pkg
// Shared definitions for the bilinear resize frame controller: the
// controller state encoding, dimension and output-count widths, and the
// default legal maxima for the input frame geometry.
// ---------------------------------------------------------------------------
package resize_pkg;

  localparam int DIM_W     = 10;   // width/height fields
  localparam int OCNT_W    = 20;   // output pixel count (10x10 product)
  localparam int MAX_W_DEF = 1023;
  localparam int MAX_H_DEF = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_BLANK,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/resize_drain_mon.sv
// ---------------------------------------------------------------------------
// resize_drain_mon
// Tracks datapath output progress for one frame.
//   clk, rst_n     : clock, asynchronous active-low reset
//   load           : legal frame start; clears the count, registers the
//                    expected output count out_width*out_height
//   count_en       : frame in flight; o_data_en strobes are counted
//   drain          : controller is in DRAIN; idle timer runs
//   o_data_en      : datapath output pixel strobe
//   out_width/height: expected output geometry, sampled on load
//   count_met      : expected count reached, including this cycle's strobe
//   timeout        : DRAIN_TIMEOUT consecutive strobe-free DRAIN cycles
// ---------------------------------------------------------------------------
module resize_drain_mon
  import resize_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             count_en,
  input  logic             drain,
  input  logic             o_data_en,
  input  logic [DIM_W-1:0] out_width,
  input  logic [DIM_W-1:0] out_height,
  output logic             count_met,
  output logic             timeout
);

  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 2);

  logic [OCNT_W-1:0] out_cnt_q, out_cnt_d, out_cnt_inc;
  logic [OCNT_W-1:0] exp_cnt_q, exp_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  always_comb begin
    out_cnt_inc = out_cnt_q + OCNT_W'(o_data_en);
    out_cnt_d   = out_cnt_q;
    exp_cnt_d   = exp_cnt_q;
    if (load) begin
      out_cnt_d = '0;
      exp_cnt_d = OCNT_W'(out_width) * OCNT_W'(out_height);
    end else if (count_en) begin
      out_cnt_d = out_cnt_inc;
    end
    if (!drain || o_data_en) idle_d = '0;
    else                     idle_d = idle_q + IDLE_W'(1);
  end

  // Compare against the post-increment count so DONE follows the final
  // strobe by one cycle instead of two.
  assign count_met = (out_cnt_inc >= exp_cnt_q);
  assign timeout   = drain && !o_data_en && (idle_q == IDLE_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
      exp_cnt_q <= '0;
      idle_q    <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      exp_cnt_q <= exp_cnt_d;
      idle_q    <= idle_d;
    end
  end

endmodule

// File: rtl/resize_frame_ctrl.sv
// ---------------------------------------------------------------------------
// resize_frame_ctrl
// Frame sequencer in front of the bilinear resize datapath. Accepts a
// valid/ready pixel stream, latches geometry at start, forwards pixels with
// programmable inter-row blanking, then waits for the datapath's output
// count to complete the frame (or time out).
//   start/abort         : frame request (IDLE only) / synchronous abort
//   cfg_*               : geometry, blanking and expected output size
//   s_valid/s_data/s_ready : source pixel stream
//   in_data_en/data_in  : registered datapath pixel strobe and data
//   width_in/height_in  : latched frame geometry
//   o_data_en           : datapath output strobe
//   busy, frame_done, err_cfg, err_timeout, frame_cnt : status
// ---------------------------------------------------------------------------
module resize_frame_ctrl
  import resize_pkg::*;
#(
  parameter int MAX_W         = MAX_W_DEF,
  parameter int MAX_H         = MAX_H_DEF,
  parameter int DRAIN_TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [DIM_W-1:0] cfg_hblank,
  input  logic [DIM_W-1:0] cfg_out_width,
  input  logic [DIM_W-1:0] cfg_out_height,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             in_data_en,
  output logic [7:0]       data_in,
  output logic [DIM_W-1:0] width_in,
  output logic [DIM_W-1:0] height_in,
  input  logic             o_data_en,
  output logic             busy,
  output logic             frame_done,
  output logic             err_cfg,
  output logic             err_timeout,
  output logic [15:0]      frame_cnt
);

  state_e           state_q, state_d;
  logic             s_ready_q, s_ready_d, busy_q, busy_d;
  logic             in_data_en_q, in_data_en_d;
  logic [7:0]       data_in_q, data_in_d;
  logic [DIM_W-1:0] width_q, width_d, height_q, height_d, hblank_q, hblank_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d, blank_q, blank_d;
  logic             frame_done_q, frame_done_d, err_cfg_q, err_cfg_d;
  logic             err_timeout_q, err_timeout_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic cfg_ok, accept, load, count_met, timeout;

  assign cfg_ok = (cfg_width  >= DIM_W'(2)) && (int'(cfg_width)  <= MAX_W) &&
                  (cfg_height >= DIM_W'(2)) && (int'(cfg_height) <= MAX_H) &&
                  (cfg_out_width != '0) && (cfg_out_height != '0);
  assign accept = s_valid && s_ready_q;
  assign load   = (state_q == ST_IDLE) && start && cfg_ok && !abort;

  resize_drain_mon #(.DRAIN_TIMEOUT(DRAIN_TIMEOUT)) u_drain_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .count_en  ((state_q == ST_ROW) || (state_q == ST_BLANK) || (state_q == ST_DRAIN)),
    .drain     (state_q == ST_DRAIN),
    .o_data_en (o_data_en),
    .out_width (cfg_out_width),
    .out_height(cfg_out_height),
    .count_met (count_met),
    .timeout   (timeout)
  );

  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    height_d      = height_q;
    hblank_d      = hblank_q;
    col_d         = col_q;
    row_d         = row_q;
    blank_d       = blank_q;
    frame_cnt_d   = frame_cnt_q;
    frame_done_d  = 1'b0;
    err_cfg_d     = 1'b0;
    err_timeout_d = 1'b0;
    in_data_en_d  = accept && !abort;
    data_in_d     = accept ? s_data : data_in_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            width_d  = cfg_width;
            height_d = cfg_height;
            hblank_d = cfg_hblank;
            col_d    = '0;
            row_d    = '0;
            blank_d  = '0;
            state_d  = ST_ROW;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      ST_ROW: begin
        if (accept) begin
          if (col_q == width_q - DIM_W'(1)) begin
            col_d   = '0;
            row_d   = row_q + DIM_W'(1);
            blank_d = '0;
            if (row_q == height_q - DIM_W'(1)) state_d = ST_DRAIN;
            else if (hblank_q != '0)           state_d = ST_BLANK;
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end
      ST_BLANK: begin
        if (blank_q == hblank_q - DIM_W'(1)) begin
          blank_d = '0;
          state_d = ST_ROW;
        end else begin
          blank_d = blank_q + DIM_W'(1);
        end
      end
      ST_DRAIN: begin
        if (count_met) begin
          state_d = ST_DONE;
        end else if (timeout) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_DONE: begin
        // DONE spans two cycles so busy stays high while frame_done is
        // visible; a start issued alongside frame_done is then ignored.
        if (frame_done_q) begin
          state_d = ST_IDLE;
        end else begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d       = ST_IDLE;
      frame_done_d  = 1'b0;
      err_cfg_d     = 1'b0;
      err_timeout_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;
    end

    s_ready_d = (state_d == ST_ROW);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      in_data_en_q  <= 1'b0;
      data_in_q     <= '0;
      width_q       <= '0;
      height_q      <= '0;
      hblank_q      <= '0;
      col_q         <= '0;
      row_q         <= '0;
      blank_q       <= '0;
      frame_done_q  <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      in_data_en_q  <= in_data_en_d;
      data_in_q     <= data_in_d;
      width_q       <= width_d;
      height_q      <= height_d;
      hblank_q      <= hblank_d;
      col_q         <= col_d;
      row_q         <= row_d;
      blank_q       <= blank_d;
      frame_done_q  <= frame_done_d;
      err_cfg_q     <= err_cfg_d;
      err_timeout_q <= err_timeout_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign busy        = busy_q;
  assign in_data_en  = in_data_en_q;
  assign data_in     = data_in_q;
  assign width_in    = width_q;
  assign height_in   = height_q;
  assign frame_done  = frame_done_q;
  assign err_cfg     = err_cfg_q;
  assign err_timeout = err_timeout_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_resize_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_resize_frame_ctrl
// Directed bench for resize_frame_ctrl: basic frame with blanking, illegal
// configuration, stalled source, drain timeout, abort and back-to-back
// frames. Expected values are hand-derived from the frame geometry.
// ---------------------------------------------------------------------------
module tb_resize_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, s_valid, o_data_en;
  logic [9:0] cfg_width, cfg_height, cfg_hblank, cfg_out_width, cfg_out_height;
  logic [7:0] s_data, data_in;
  logic       s_ready, in_data_en, busy, frame_done, err_cfg, err_timeout;
  logic [9:0] width_in, height_in;
  logic [15:0] frame_cnt;

  resize_frame_ctrl #(.MAX_W(1023), .MAX_H(1023), .DRAIN_TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_hblank(cfg_hblank),
    .cfg_out_width(cfg_out_width), .cfg_out_height(cfg_out_height),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .in_data_en(in_data_en), .data_in(data_in),
    .width_in(width_in), .height_in(height_in), .o_data_en(o_data_en),
    .busy(busy), .frame_done(frame_done), .err_cfg(err_cfg),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled on the falling edge.
  int         ide_cyc[$];
  logic [7:0] ide_dat[$];
  int         done_cyc[$], to_cyc[$], cfgerr_cyc[$], st_cyc[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_data_en) begin ide_cyc.push_back(cyc); ide_dat.push_back(data_in); end
      if (frame_done)  done_cyc.push_back(cyc);
      if (err_timeout) to_cyc.push_back(cyc);
      if (err_cfg)     cfgerr_cyc.push_back(cyc);
      if (o_data_en)   st_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixels(input int n, input bit toggle, input logic [7:0] base);
    int p = 0;
    int g = 0;
    bit hs;
    while (p < n && g < 2000) begin
      s_valid = toggle ? (g % 2 == 0) : 1'b1;
      s_data  = base + 8'(p);
      hs      = s_valid && s_ready;
      tick();
      if (hs) p++;
      g++;
    end
    s_valid = 1'b0;
    chk("src_budget", p, n);
  endtask

  task automatic emit_strobes(input int n, input int dly);
    repeat (dly) tick();
    repeat (n) begin
      o_data_en = 1'b1;
      tick();
    end
    o_data_en = 1'b0;
  endtask

  // Starts a frame, runs source and datapath model, and returns in the
  // cycle frame_done or err_timeout is visible.
  task automatic run_frame(input int w, input int h, input int hb, input int ow,
                           input int oh, input int ns, input int sd,
                           input bit tog, input logic [7:0] base);
    int g = 0;
    cfg_width = 10'(w); cfg_height = 10'(h); cfg_hblank = 10'(hb);
    cfg_out_width = 10'(ow); cfg_out_height = 10'(oh);
    start = 1'b1;
    tick();
    start = 1'b0;
    fork
      send_pixels(w * h, tog, base);
      emit_strobes(ns, sd);
    join
    while (!frame_done && !err_timeout && g < 300) begin
      tick();
      g++;
    end
    chk("frame_end_wait", 32'(g < 300), 1);
  endtask

  task automatic chk_data(input string tag, input int b, input int n, input logic [7:0] base);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (ide_dat[b + i] !== base + 8'(i)) bad++;
    chk(tag, bad, 0);
  endtask

  int bi, bd, bt, bc, bs, gapbad, p, g, exp_frames;
  bit hs, aborted;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    o_data_en = 1'b0; cfg_width = '0; cfg_height = '0; cfg_hblank = '0;
    cfg_out_width = '0; cfg_out_height = '0;
    exp_frames = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_in_data_en", 32'(in_data_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({frame_done, err_cfg, err_timeout}), 0);
    chk("rst_data_in", 32'(data_in), 0);
    chk("rst_geom", 32'({width_in, height_in}), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Basic 4x3 frame, hblank 2, 8x6 output strobes.
    bi = ide_cyc.size(); bd = done_cyc.size();
    run_frame(4, 3, 2, 8, 6, 48, 3, 1'b0, 8'h10);
    exp_frames++;
    chk("t1_busy_at_done", 32'(busy), 1);
    tick();
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_ide_n", ide_cyc.size() - bi, 12);
    chk_data("t1_data", bi, 12, 8'h10);
    gapbad = 0;
    for (int i = 1; i < 12; i++)
      if (ide_cyc[bi + i] - ide_cyc[bi + i - 1] != ((i % 4 == 0) ? 3 : 1)) gapbad++;
    chk("t1_row_gap", gapbad, 0);
    chk("t1_done_n", done_cyc.size() - bd, 1);
    chk("t1_done_lat", done_cyc[$] - st_cyc[$], 2);
    chk("t1_frame_cnt", 32'(frame_cnt), exp_frames);
    chk("t1_width_in", 32'(width_in), 4);
    chk("t1_height_in", 32'(height_in), 3);

    // Illegal configurations: width 1, then output height 0.
    cfg_width = 10'd1; cfg_height = 10'd3; cfg_out_width = 10'd2; cfg_out_height = 10'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_err_cfg", 32'(err_cfg), 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_s_ready", 32'(s_ready), 0);
    tick();
    chk("t2_err_cfg_pulse", 32'(err_cfg), 0);
    chk("t2_busy_hold", 32'(busy), 0);
    cfg_width = 10'd4; cfg_out_height = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_err_cfg_oh0", 32'(err_cfg), 1);
    chk("t2_busy_oh0", 32'(busy), 0);
    chk("t2_width_kept", 32'(width_in), 4);
    tick();

    // Source stalls: 4x2 frame, s_valid toggling.
    bi = ide_cyc.size(); bd = done_cyc.size();
    run_frame(4, 2, 1, 2, 1, 2, 2, 1'b1, 8'h40);
    exp_frames++;
    tick();
    chk("t3_ide_n", ide_cyc.size() - bi, 8);
    chk_data("t3_data", bi, 8, 8'h40);
    chk("t3_done_n", done_cyc.size() - bd, 1);
    chk("t3_frame_cnt", 32'(frame_cnt), exp_frames);

    // Drain timeout: 16 expected, 10 delivered.
    bi = ide_cyc.size(); bd = done_cyc.size(); bt = to_cyc.size(); bs = st_cyc.size();
    run_frame(2, 2, 0, 4, 4, 10, 10, 1'b0, 8'h60);
    chk("t4_err_timeout", 32'(err_timeout), 1);
    tick();
    chk("t4_err_pulse", 32'(err_timeout), 0);
    chk("t4_to_n", to_cyc.size() - bt, 1);
    chk("t4_strobes", st_cyc.size() - bs, 10);
    chk("t4_to_lat", to_cyc[$] - st_cyc[$], 21);
    chk("t4_done_n", done_cyc.size() - bd, 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_ide_n", ide_cyc.size() - bi, 4);
    chk("t4_frame_cnt", 32'(frame_cnt), exp_frames);

    // Abort with simultaneous start, mid row 2 of a 4x4 frame.
    bi = ide_cyc.size(); bd = done_cyc.size(); bt = to_cyc.size(); bc = cfgerr_cyc.size();
    cfg_width = 10'd4; cfg_height = 10'd4; cfg_hblank = 10'd1;
    cfg_out_width = 10'd2; cfg_out_height = 10'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    p = 0; g = 0; aborted = 1'b0;
    s_valid = 1'b1;
    while (!aborted && g < 200) begin
      s_data = 8'h70 + 8'(p);
      hs = s_ready;
      if (hs && p == 6) begin abort = 1'b1; start = 1'b1; end
      tick();
      if (abort) aborted = 1'b1;
      else if (hs) p++;
      g++;
    end
    chk("t5_reached", 32'(aborted), 1);
    chk("t5_in_data_en", 32'(in_data_en), 0);
    chk("t5_s_ready", 32'(s_ready), 0);
    chk("t5_busy", 32'(busy), 0);
    abort = 1'b0; start = 1'b0; s_valid = 1'b0;
    repeat (5) tick();
    chk("t5_ide_n", ide_cyc.size() - bi, 6);
    chk("t5_pulses", (done_cyc.size() - bd) + (to_cyc.size() - bt) + (cfgerr_cyc.size() - bc), 0);
    chk("t5_frame_cnt", 32'(frame_cnt), exp_frames);
    bi = ide_cyc.size(); bd = done_cyc.size();
    run_frame(2, 2, 1, 2, 2, 4, 2, 1'b0, 8'h80);
    exp_frames++;
    tick();
    chk("t5_clean_ide_n", ide_cyc.size() - bi, 4);
    chk_data("t5_clean_data", bi, 4, 8'h80);
    chk("t5_clean_done", done_cyc.size() - bd, 1);
    chk("t5_clean_cnt", 32'(frame_cnt), exp_frames);

    // Back-to-back: start during frame_done is ignored.
    run_frame(2, 2, 0, 1, 2, 2, 1, 1'b0, 8'hA0);
    exp_frames++;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_start_ignored_busy", 32'(busy), 0);
    chk("t6_start_ignored_rdy", 32'(s_ready), 0);
    bd = done_cyc.size();
    run_frame(3, 2, 0, 1, 2, 2, 1, 1'b0, 8'hB0);
    exp_frames++;
    tick();
    chk("t6_done_n", done_cyc.size() - bd, 1);
    chk("t6_frame_cnt", 32'(frame_cnt), exp_frames);
    chk("t6_width_in", 32'(width_in), 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "simulation time limit");
  end

endmodule
